jtag_probe_wb_bridge: RTL and testbench
=======================================

Name: jtag_probe_wb_bridge

Overview:
- Clock-domain-crossing bridge between the JTAG source/probe register pair and a Wishbone master port in the system clock domain.
- Consumes the tck-domain source word as a command: request toggle, we, address and write data.
- Executes exactly one single Wishbone classic transfer per toggle flip.
- Returns status and read data on the probe word, which the host reads back over JTAG.

Parameters:
- Aw, 32, Wishbone address width in bits.
- Dw, 32, Wishbone data width in bits.
- TIMEOUT, 255, maximum cycles to wait for ack/err before aborting; minimum 1.
- SRC_W, Aw+Dw+2, width of jtag_source; derived, never overridden.
- PRB_W, Dw+3, width of jtag_probe; derived, never overridden.

Ports:
- clk  input  1  system clock; the only clock of the block.
- reset  input  1  asynchronous, active-low reset.
- jtag_source  input  SRC_W  command word from the JTAG source register (tck domain).
  - [SRC_W-1] req_toggle.
  - [SRC_W-2] we.
  - [Aw+Dw-1:Dw] addr.
  - [Dw-1:0] wdata.
- jtag_probe  output  PRB_W  status word to the JTAG probe input.
  - [Dw+2] done_toggle.
  - [Dw+1] err.
  - [Dw] busy.
  - [Dw-1:0] rdata.
- m_adr_o  output  Aw  Wishbone address.
- m_dat_o  output  Dw  Wishbone write data.
- m_sel_o  output  Dw/8  byte select; all ones whenever cyc is high.
- m_we_o  output  1  write enable.
- m_cyc_o  output  1  cycle.
- m_stb_o  output  1  strobe; always equal to m_cyc_o.
- m_dat_i  input  Dw  Wishbone read data.
- m_ack_i  input  1  acknowledge.
- m_err_i  input  1  bus error.

Behaviour:
- Reset (async assert, sync release):
  - All Wishbone outputs 0.
  - jtag_probe all 0.
  - req_seen 0, timeout counter 0, state INIT.
- Synchronizer:
  - Only req_toggle passes through a 2-FF synchronizer (tog_s1, tog_s2).
  - The remaining source bits are sampled directly in CAPTURE. This is legal because the host changes the whole source word on one tck edge and the toggle only becomes visible after 2 clk edges. These bits are a declared false path.
- FSM states: INIT, IDLE, CAPTURE, BUS, DONE.
  - INIT: waits 3 cycles (timeout counter reused), then sets req_seen<=tog_s2 and enters IDLE. No transfer is issued, so a stale toggle left from before reset never fires.
  - IDLE: if tog_s2!=req_seen, go to CAPTURE and set busy<=1. Otherwise stay in IDLE.
  - CAPTURE (1 cycle):
    - Register addr->m_adr_o, wdata->m_dat_o, we->m_we_o.
    - req_seen<=tog_s2; counter cleared.
    - Next state BUS, with cyc/stb/sel asserted on entry.
  - BUS: cyc/stb held high with stable adr/dat/we. Each cycle, checked in this order:
    - m_err_i=1 -> err<=1, go to DONE. err has priority if ack and err arrive in the same cycle.
    - Else m_ack_i=1 -> err<=0; if !we, rdata<=m_dat_i; go to DONE.
    - Else if counter==TIMEOUT-1 -> err<=1, go to DONE (abort).
    - Else counter+1.
    - On leaving BUS, cyc/stb/sel drop in the same registered update.
  - DONE (1 cycle): busy<=0, done_toggle<=~done_toggle, go to IDLE.
- Field rules:
  - rdata is unchanged on writes, on errors and on timeouts.
  - err reflects only the most recent transfer.
- Latency:
  - m_cyc_o rises on the 4th clk edge after the first edge at which tog_s1 samples the new toggle. That is 2 sync edges, then IDLE->CAPTURE, then CAPTURE->BUS.
  - With a zero-wait slave (ack in the first BUS cycle), cyc is high for exactly 1 cycle and done_toggle flips 2 edges after cyc rises.
- Host protocol:
  - Write source with req_toggle inverted.
  - Poll probe until done_toggle equals the written toggle, then read err/rdata.
  - A toggle flip that arrives while busy is held in tog_s2 and served after returning to IDLE. At most one pending request exists; if the toggle flips twice during busy, the net toggle equals req_seen and nothing is issued.
- Reset mid-transfer: cyc/stb drop immediately (async), probe clears, FSM re-enters INIT.

Test Plan:
- Write: source={tog=1,we=1,addr=0x10,wdata=0xDEADBEEF}, slave acks after 2 wait cycles -> one cycle with adr=0x10, dat=0xDEADBEEF, we=1, sel=0xF; cyc high 3 cycles; probe done_toggle=1, err=0, busy=0, rdata=0.
- Read: tog=0, we=0, addr=0x10, slave returns 0x12345678 with zero wait -> cyc high 1 cycle; probe={done=0, err=0, busy=0, rdata=0x12345678}; cyc rises 4 edges after the toggle change.
- Error/priority: slave asserts ack and err together -> err=1, rdata keeps its previous value, done_toggle flips.
- Timeout: TIMEOUT=8, slave never responds -> cyc high exactly 8 cycles, then err=1 and done_toggle flips; the next request succeeds normally.
- Stale toggle: hold jtag_source tog=1, pulse reset low -> no cyc assertion within 20 cycles after release; probe stays 0 until the toggle changes to 0.
- Reset mid-BUS: assert reset while cyc=1 -> cyc/stb/probe go to 0 without waiting for a clk edge; after release, INIT completes with no transfer issued.

Source files
------------

// File: rtl/jtag_probe_wb_bridge.sv
// Bridges the JTAG source/probe register pair to a Wishbone classic master:
// one toggle flip on the source word runs exactly one bus transfer.
module jtag_probe_wb_bridge #(
    parameter int Aw      = 32,
    parameter int Dw      = 32,
    parameter int TIMEOUT = 255,
    localparam int SRC_W  = Aw + Dw + 2,
    localparam int PRB_W  = Dw + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SRC_W-1:0]  jtag_source,
    output logic [PRB_W-1:0]  jtag_probe,
    output logic [Aw-1:0]     m_adr_o,
    output logic [Dw-1:0]     m_dat_o,
    output logic [Dw/8-1:0]   m_sel_o,
    output logic              m_we_o,
    output logic              m_cyc_o,
    output logic              m_stb_o,
    input  logic [Dw-1:0]     m_dat_i,
    input  logic              m_ack_i,
    input  logic              m_err_i
);

    localparam int CW = $clog2(TIMEOUT + 4);

    typedef enum logic [2:0] {INIT, IDLE, CAPTURE, BUS, DONE} state_t;

    state_t            r_state;
    logic              r_tog_s1, r_tog_s2, r_req_seen;
    logic [CW-1:0]     r_cnt;
    logic [Aw-1:0]     r_adr;
    logic [Dw-1:0]     r_dat;
    logic [Dw/8-1:0]   r_sel;
    logic              r_we, r_cyc;
    logic              r_done_tog, r_err, r_busy;
    logic [Dw-1:0]     r_rdata;

    logic              w_req_tog, w_we;
    logic [Aw-1:0]     w_addr;
    logic [Dw-1:0]     w_wdata;

    // Only the toggle is synchronized; the other fields are stable by the
    // time the synchronized toggle is seen and are sampled raw in CAPTURE.
    assign w_req_tog = jtag_source[SRC_W-1];
    assign w_we      = jtag_source[SRC_W-2];
    assign w_addr    = jtag_source[Aw+Dw-1:Dw];
    assign w_wdata   = jtag_source[Dw-1:0];

    assign m_adr_o    = r_adr;
    assign m_dat_o    = r_dat;
    assign m_sel_o    = r_sel;
    assign m_we_o     = r_we;
    assign m_cyc_o    = r_cyc;
    assign m_stb_o    = r_cyc;
    assign jtag_probe = {r_done_tog, r_err, r_busy, r_rdata};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= INIT;
            r_tog_s1   <= 1'b0;
            r_tog_s2   <= 1'b0;
            r_req_seen <= 1'b0;
            r_cnt      <= '0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_sel      <= '0;
            r_we       <= 1'b0;
            r_cyc      <= 1'b0;
            r_done_tog <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_tog_s1 <= w_req_tog;
            r_tog_s2 <= r_tog_s1;
            case (r_state)
                // Adopt whatever toggle is present after reset so a stale one never fires.
                INIT: begin
                    if (r_cnt == CW'(2)) begin
                        r_req_seen <= r_tog_s2;
                        r_cnt      <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                IDLE: begin
                    if (r_tog_s2 != r_req_seen) begin
                        r_busy  <= 1'b1;
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_adr      <= w_addr;
                    r_dat      <= w_wdata;
                    r_we       <= w_we;
                    r_req_seen <= r_tog_s2;
                    r_cnt      <= '0;
                    r_cyc      <= 1'b1;
                    r_sel      <= '1;
                    r_state    <= BUS;
                end
                BUS: begin
                    if (m_err_i) begin
                        r_err   <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_sel   <= '0;
                        r_state <= DONE;
                    end else if (m_ack_i) begin
                        r_err <= 1'b0;
                        if (!r_we) r_rdata <= m_dat_i;
                        r_cyc   <= 1'b0;
                        r_sel   <= '0;
                        r_state <= DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_sel   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_busy     <= 1'b0;
                    r_done_tog <= ~r_done_tog;
                    r_state    <= IDLE;
                end
                default: r_state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_probe_wb_bridge.sv
// Directed plus randomized checks of the JTAG-to-Wishbone bridge against a
// transaction-level model of the host-visible probe word and bus timing.
module tb_jtag_probe_wb_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [65:0] jtag_source;
    logic [34:0] jtag_probe;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i, m_err_i;

    int checks = 0;
    int errors = 0;

    logic        host_tog;
    logic        done_m, err_m;
    logic [31:0] rdata_m;

    jtag_probe_wb_bridge #(.Aw(32), .Dw(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .jtag_source(jtag_source), .jtag_probe(jtag_probe),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_we_o(m_we_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_dat_i(m_dat_i),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 = ack, 1 = err, 2 = ack and err together; response comes after
    // `waits` wait states, so waits >= TMO means the slave never answers in time.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input int waits, input int mode);
        int  k;
        int  hi;
        int  exp_hi;
        bit  bad;
        bit  tmo;
        host_tog    = ~host_tog;
        jtag_source = {host_tog, we, addr, wdata};
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_cyc_o && k < 20);
        check("cyc_latency", 64'(k), 64'd4);
        hi  = 0;
        bad = 0;
        while (m_cyc_o && hi < 300) begin
            if (m_adr_o !== addr || m_dat_o !== wdata || m_we_o !== we ||
                m_sel_o !== 4'hF || m_stb_o !== 1'b1 || jtag_probe[32] !== 1'b1) bad = 1;
            m_ack_i = (hi == waits) && (mode != 1);
            m_err_i = (hi == waits) && (mode != 0);
            m_dat_i = (hi == waits) ? rd : $urandom;
            @(negedge clk);
            hi++;
        end
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        tmo    = (waits >= TMO);
        exp_hi = tmo ? TMO : waits + 1;
        check("bus_stable", 64'(bad), 64'd0);
        check("cyc_cycles", 64'(hi), 64'(exp_hi));
        check("idle_bus", {m_stb_o, m_sel_o}, 64'd0);
        check("done_not_yet", 64'(jtag_probe[34]), 64'(done_m));
        @(negedge clk);
        done_m = ~done_m;
        err_m  = tmo || (mode != 0);
        if (!err_m && !we) rdata_m = rd;
        check("probe", 64'(jtag_probe), {29'd0, done_m, err_m, 1'b0, rdata_m});
    endtask

    initial begin
        bit cyc_seen;
        bit probe_nz;
        int k;
        reset       = 1'b0;
        jtag_source = '0;
        m_ack_i     = 1'b0;
        m_err_i     = 1'b0;
        m_dat_i     = '0;
        host_tog    = 1'b0;
        done_m      = 1'b0;
        err_m       = 1'b0;
        rdata_m     = '0;
        repeat (3) @(negedge clk);
        check("reset_probe", 64'(jtag_probe), 64'd0);
        check("reset_bus", {m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o}, 64'd0);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        xfer(1'b1, 32'h10, 32'hDEADBEEF, 32'hA5A5A5A5, 2, 0);
        xfer(1'b0, 32'h10, 32'h0, 32'h12345678, 0, 0);
        xfer(1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1, 2);
        xfer(1'b0, 32'h24, 32'h0, 32'hBADBAD00, 0, 1);
        xfer(1'b0, 32'h30, 32'h0, 32'h55555555, 100, 0);
        xfer(1'b0, 32'h34, 32'h0, 32'h0BADF00D, TMO - 1, 0);
        xfer(1'b1, 32'h38, 32'h11112222, 32'h0, TMO, 0);

        for (int i = 0; i < 16; i++)
            xfer(1'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 10)), int'($urandom_range(0, 2)));

        // Stale toggle across reset must not fire a transfer.
        host_tog    = ~host_tog;
        jtag_source = {host_tog, 1'b0, 32'h40, 32'h0};
        reset       = 1'b0;
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        cyc_seen = 0;
        probe_nz = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_cyc_o) cyc_seen = 1;
            if (jtag_probe != '0) probe_nz = 1;
        end
        check("stale_no_cyc", 64'(cyc_seen), 64'd0);
        check("stale_probe_zero", 64'(probe_nz), 64'd0);
        done_m  = 1'b0;
        err_m   = 1'b0;
        rdata_m = '0;
        xfer(1'b0, 32'h44, 32'h0, 32'h87654321, 1, 0);

        // Reset while the bus cycle is open must clear outputs without a clock edge.
        host_tog    = ~host_tog;
        jtag_source = {host_tog, 1'b1, 32'h50, 32'hFEEDFACE};
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_cyc_o && k < 20);
        check("midbus_cyc_up", 64'(m_cyc_o), 64'd1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midbus_async_clear", {m_cyc_o, m_stb_o, m_sel_o, jtag_probe}, 64'd0);
        @(negedge clk);
        reset    = 1'b1;
        cyc_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_cyc_o) cyc_seen = 1;
        end
        check("midbus_no_reissue", 64'(cyc_seen), 64'd0);
        done_m  = 1'b0;
        err_m   = 1'b0;
        rdata_m = '0;
        xfer(1'b0, 32'h54, 32'h0, 32'h13579BDF, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
